exec_pipe_chain: RTL and testbench
==================================

# exec_pipe_chain

Parametrised multi-lane execute pipeline register chain for the dual-issue core. It carries issued operations from issue to commit through STAGES register stages and LANES parallel lanes. It applies global stall, young/all flush and per-stage late-result updates, such as multiplier partial products or memory data. It also provides a youngest-first register bypass lookup for issue.

## Interface
- LANES, 2: parallel issue lanes; lane index LANES-1 is program-order youngest within a bundle.
- STAGES, 3: pipeline register stages, ≥2; stage 0 is youngest, stage STAGES-1 is the commit stage.
- DATA_W, 32: result width.
- TAG_W, 5: destination register id width.
- QUERIES, 4: bypass lookup ports.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  LANES  issued op valid per lane.
- in_dst  in  LANES×TAG_W  destination register.
- in_wen  in  LANES  writes register.
- in_rdy  in  LANES  in_data already final (ALU result).
- in_data  in  LANES×DATA_W  result or partial value.
- stall  in  1  mem/div halt.
- flush_young  in  1  branch mispredict; discards the incoming bundle.
- flush_all  in  1  exception/eret; kills everything.
- upd_en  in  STAGES×LANES  late result for the entry in stage s, lane l.
- upd_data  in  STAGES×LANES×DATA_W  late result value.
- out_valid, out_dst, out_wen, out_data  out  LANES / ×TAG_W / LANES / ×DATA_W  commit-stage contents.
- q_reg  in  QUERIES×TAG_W  register to look up.
- q_hit  out  QUERIES  a valid in-flight writer exists.
- q_rdy  out  QUERIES  the youngest writer's data is final.
- q_data  out  QUERIES×DATA_W  the youngest writer's data.
- busy  out  1  any valid entry in any stage.

## Operation
- Entry fields are valid, dst, wen, rdy and data. Reset clears every stage: all fields 0, so out_valid=0, busy=0, q_hit=0.
- Effective entry E(s,l): the stored entry with data replaced by upd_data and rdy forced to 1 when upd_en[s][l]=1. Updates on invalid entries are ignored.
- Priority each cycle: resetn=0 > flush_all > stall > normal.
- flush_all: every stage is loaded with a bubble (valid=0). Inputs and updates are discarded.
- stall, regardless of flush_young:
  - stages 0..STAGES-2 hold E(s,l), so updates are captured in place;
  - the commit stage loads a bubble;
  - the incoming bundle is discarded. Issue must not present it while stalled.
- Normal:
  - stage s+1 loads E(s,l);
  - stage 0 loads the input bundle, or a bubble if flush_young=1.
  - Older stages are unaffected by flush_young.
- Input entry: valid=in_valid, dst=in_dst, wen=in_wen&in_valid, rdy=in_rdy, data=in_data.
- Lookup, per query q:
  - candidates are E(s,l) with valid & wen & dst==q_reg[q] & q_reg[q]!=0;
  - priority is lowest s, then highest l within a stage;
  - q_hit reports whether a candidate exists; q_rdy and q_data come from the winner;
  - with no hit, q_rdy=0 and q_data=0;
  - lookup is purely combinational on the current state plus upd.
- busy is the OR of all stored valid bits.

## Timing
- Latency: input at edge t appears at out_* after edge t+STAGES-1, i.e. STAGES cycles from issue to commit visibility, when there are no stalls.
- Each stall cycle adds exactly one cycle of latency and produces exactly one commit bubble.
- An update in cycle t is visible in stage s+1 (normal) or stage s (stall) after edge t. Lookups see it in cycle t.
- flush_young asserted together with flush_all behaves as flush_all. Asserted together with stall, it behaves as stall.
- A stall released in cycle t: the contents of stage STAGES-2 reach commit at edge t.
- Reset mid-operation clears all stages on the next edge. Updates are ignored during that cycle.

## Structure
- Shared package: typedef pipe_entry_t {valid, dst, wen, rdy, data}, parameterised via package constants PIPE_TAG_W and PIPE_DATA_W. Also holds the zero-register constant REG_ZERO.
- One sub-module, pipe_bypass_lookup: combinational youngest-first priority search of the effective entries for one query, instantiated QUERIES times.
- Stage registers are held in a 2-D array of pipe_entry_t, driven by a single always_ff with the priority above.

## Test plan
- Reset then single issue: lane0 {dst=5, wen, rdy, data=0x11} at t0. Required: out_valid[0]=1, out_data=0x11 at t0+3 with STAGES=3; busy drops one cycle after it leaves commit.
- Stall: issue at t0, stall in t1–t2. Required: commit bubbles at t1 and t2; entry commits at t0+5; total count committed equals total count issued.
- flush_young at t2 with entries issued at t0,t1,t2. Required: the t2 bundle never commits; the t0 and t1 bundles commit normally. flush_all at t3 with the same issues: nothing commits.
- Update: lane1 {dst=7, rdy=0, data=0}. upd_en[1][1] with 0xABCD in stage 1. Required: out_data[1]=0xABCD; a query for 7 gives q_rdy=1, q_data=0xABCD in the update cycle.
- Bypass priority: stage2 lane0 dst=3 data=1; stage1 lane1 dst=3 data=2; stage1 lane0 dst=3 data=4. Required: q_data=2. q_reg=0 gives q_hit=0. An entry with wen=0 never hits.

Source files
------------

// File: rtl/exec_pipe_chain_pkg.sv
// ============================================================================
// exec_pipe_chain_pkg: shared entry type and constants for the execute chain.
// Rev 1.0
// ============================================================================
`default_nettype none

package exec_pipe_chain_pkg;

  localparam int PIPE_TAG_W  = 5;
  localparam int PIPE_DATA_W = 32;

  localparam logic [PIPE_TAG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_TAG_W-1:0]  dst;
    logic                   wen;
    logic                   rdy;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

endpackage

`default_nettype wire

// File: rtl/exec_pipe_chain_lookup.sv
// ============================================================================
// pipe_bypass_lookup: youngest-first search of in-flight writers for one reg.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_bypass_lookup
  import exec_pipe_chain_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int STAGES = 3
) (
  input  pipe_entry_t [STAGES-1:0][LANES-1:0] ents,
  input  logic [PIPE_TAG_W-1:0]               reg_id,
  output logic                                hit,
  output logic                                rdy,
  output logic [PIPE_DATA_W-1:0]              data
);

  // Scan oldest-to-youngest so the last match written is the youngest writer.
  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (ents[s][l].valid && ents[s][l].wen &&
            (ents[s][l].dst == reg_id) && (reg_id != REG_ZERO)) begin
          hit  = 1'b1;
          rdy  = ents[s][l].rdy;
          data = ents[s][l].data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/exec_pipe_chain.sv
// ============================================================================
// exec_pipe_chain: multi-lane issue-to-commit register chain with stall,
// flush, late-result update and bypass lookup.  Rev 1.0
// ============================================================================
`default_nettype none

module exec_pipe_chain
  import exec_pipe_chain_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int STAGES  = 3,
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int TAG_W   = PIPE_TAG_W,
  parameter int QUERIES = 4
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic [LANES-1:0]                            in_valid,
  input  logic [LANES-1:0][TAG_W-1:0]                 in_dst,
  input  logic [LANES-1:0]                            in_wen,
  input  logic [LANES-1:0]                            in_rdy,
  input  logic [LANES-1:0][DATA_W-1:0]                in_data,
  input  logic                                        stall,
  input  logic                                        flush_young,
  input  logic                                        flush_all,
  input  logic [STAGES-1:0][LANES-1:0]                upd_en,
  input  logic [STAGES-1:0][LANES-1:0][DATA_W-1:0]    upd_data,
  output logic [LANES-1:0]                            out_valid,
  output logic [LANES-1:0][TAG_W-1:0]                 out_dst,
  output logic [LANES-1:0]                            out_wen,
  output logic [LANES-1:0][DATA_W-1:0]                out_data,
  input  logic [QUERIES-1:0][TAG_W-1:0]               q_reg,
  output logic [QUERIES-1:0]                          q_hit,
  output logic [QUERIES-1:0]                          q_rdy,
  output logic [QUERIES-1:0][DATA_W-1:0]              q_data,
  output logic                                        busy
);

  pipe_entry_t                        st  [STAGES][LANES];
  pipe_entry_t [STAGES-1:0][LANES-1:0] eff;

  // Late results only land on live entries.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      for (int l = 0; l < LANES; l++) begin
        eff[s][l] = st[s][l];
        if (upd_en[s][l] && st[s][l].valid) begin
          eff[s][l].data = upd_data[s][l];
          eff[s][l].rdy  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush_all) begin
      for (int s = 0; s < STAGES; s++)
        for (int l = 0; l < LANES; l++)
          st[s][l] <= '0;
    end else if (stall) begin
      for (int s = 0; s < STAGES - 1; s++)
        for (int l = 0; l < LANES; l++)
          st[s][l] <= eff[s][l];
      for (int l = 0; l < LANES; l++)
        st[STAGES-1][l] <= '0;
    end else begin
      for (int s = 0; s < STAGES - 1; s++)
        for (int l = 0; l < LANES; l++)
          st[s+1][l] <= eff[s][l];
      for (int l = 0; l < LANES; l++) begin
        if (flush_young) begin
          st[0][l] <= '0;
        end else begin
          st[0][l].valid <= in_valid[l];
          st[0][l].dst   <= in_dst[l];
          st[0][l].wen   <= in_wen[l] & in_valid[l];
          st[0][l].rdy   <= in_rdy[l];
          st[0][l].data  <= in_data[l];
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_out
      assign out_valid[l] = st[STAGES-1][l].valid;
      assign out_dst[l]   = st[STAGES-1][l].dst;
      assign out_wen[l]   = st[STAGES-1][l].wen;
      assign out_data[l]  = st[STAGES-1][l].data;
    end

    for (genvar q = 0; q < QUERIES; q++) begin : g_query
      pipe_bypass_lookup #(
        .LANES  (LANES),
        .STAGES (STAGES)
      ) u_lookup (
        .ents   (eff),
        .reg_id (q_reg[q]),
        .hit    (q_hit[q]),
        .rdy    (q_rdy[q]),
        .data   (q_data[q])
      );
    end
  endgenerate

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < STAGES; s++)
      for (int l = 0; l < LANES; l++)
        busy = busy | st[s][l].valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_pipe_chain.sv
// ============================================================================
// tb_exec_pipe_chain: directed vector table plus update/bypass/reset sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exec_pipe_chain;

  localparam int LANES = 2, STAGES = 3, DATA_W = 32, TAG_W = 5, QUERIES = 4;

  logic                                     clk = 1'b0;
  logic                                     resetn;
  logic [LANES-1:0]                         in_valid, in_wen, in_rdy;
  logic [LANES-1:0][TAG_W-1:0]              in_dst;
  logic [LANES-1:0][DATA_W-1:0]             in_data;
  logic                                     stall, flush_young, flush_all;
  logic [STAGES-1:0][LANES-1:0]             upd_en;
  logic [STAGES-1:0][LANES-1:0][DATA_W-1:0] upd_data;
  logic [LANES-1:0]                         out_valid, out_wen;
  logic [LANES-1:0][TAG_W-1:0]              out_dst;
  logic [LANES-1:0][DATA_W-1:0]             out_data;
  logic [QUERIES-1:0][TAG_W-1:0]            q_reg;
  logic [QUERIES-1:0]                       q_hit, q_rdy;
  logic [QUERIES-1:0][DATA_W-1:0]           q_data;
  logic                                     busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_pipe_chain #(
    .LANES(LANES), .STAGES(STAGES), .DATA_W(DATA_W), .TAG_W(TAG_W), .QUERIES(QUERIES)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_dst(in_dst), .in_wen(in_wen), .in_rdy(in_rdy), .in_data(in_data),
    .stall(stall), .flush_young(flush_young), .flush_all(flush_all),
    .upd_en(upd_en), .upd_data(upd_data),
    .out_valid(out_valid), .out_dst(out_dst), .out_wen(out_wen), .out_data(out_data),
    .q_reg(q_reg), .q_hit(q_hit), .q_rdy(q_rdy), .q_data(q_data),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_wen = '0; in_rdy = '0; in_dst = '0; in_data = '0;
    stall = 1'b0; flush_young = 1'b0; flush_all = 1'b0;
    upd_en = '0; upd_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] d0, d1;
    logic        st, fy, fa;
    logic [1:0]  ov;
    logic [31:0] o0, o1;
    logic        bz;
  } vec_t;

  vec_t tv [17];
  int   issued, committed;

  initial begin
    resetn = 1'b0;
    idle_inputs();
    q_reg = '0;
    tick(); tick();
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset q_hit", 32'(q_hit), 32'h0);
    resetn = 1'b1;

    // Lane0 dst=1, lane1 dst=2, wen/rdy set. Each row is applied before one edge
    // and checked just after it.
    tv[0]  = '{2'b01, 32'h11, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[1]  = '{2'b11, 32'h21, 32'h22, 0, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[2]  = '{2'b10, 32'h00, 32'h32, 0, 1, 0, 2'b01, 32'h11, 32'h00, 1};
    tv[3]  = '{2'b00, 32'h00, 32'h00, 0, 0, 0, 2'b11, 32'h21, 32'h22, 1};
    tv[4]  = '{2'b00, 32'h00, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 0};
    tv[5]  = '{2'b01, 32'h41, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[6]  = '{2'b00, 32'h00, 32'h00, 1, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[7]  = '{2'b00, 32'h00, 32'h00, 1, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[8]  = '{2'b00, 32'h00, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[9]  = '{2'b00, 32'h00, 32'h00, 0, 0, 0, 2'b01, 32'h41, 32'h00, 1};
    tv[10] = '{2'b00, 32'h00, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 0};
    tv[11] = '{2'b11, 32'h51, 32'h52, 0, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[12] = '{2'b01, 32'h61, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 1};
    tv[13] = '{2'b01, 32'h71, 32'h00, 0, 1, 1, 2'b00, 32'h00, 32'h00, 0};
    tv[14] = '{2'b00, 32'h00, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 0};
    tv[15] = '{2'b10, 32'h00, 32'h81, 1, 1, 0, 2'b00, 32'h00, 32'h00, 0};
    tv[16] = '{2'b00, 32'h00, 32'h00, 0, 0, 0, 2'b00, 32'h00, 32'h00, 0};

    for (int i = 0; i < 17; i++) begin
      in_valid = tv[i].vld; in_wen = 2'b11; in_rdy = 2'b11;
      in_dst[0] = 5'd1; in_dst[1] = 5'd2;
      in_data[0] = tv[i].d0; in_data[1] = tv[i].d1;
      stall = tv[i].st; flush_young = tv[i].fy; flush_all = tv[i].fa;
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tv[i].ov));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].bz));
      if (tv[i].ov[0]) check($sformatf("vec%0d out_data0", i), out_data[0], tv[i].o0);
      if (tv[i].ov[1]) check($sformatf("vec%0d out_data1", i), out_data[1], tv[i].o1);
    end
    idle_inputs();

    // Stall conservation: issue one op every cycle, stall twice in between.
    issued = 0; committed = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid   = (i < 6) ? 2'b01 : 2'b00;
      in_wen     = 2'b01;
      stall      = (i == 2 || i == 3);
      if (in_valid[0] && !stall) issued++;
      tick();
      if (out_valid[0]) committed++;
    end
    idle_inputs();
    check("stall conservation", 32'(committed), 32'(issued));

    // Late update: lane1 dst=7 not ready, completed while in stage 1.
    in_valid = 2'b10; in_wen = 2'b10; in_rdy = 2'b00; in_dst[1] = 5'd7; in_data[1] = '0;
    tick();
    idle_inputs();
    q_reg[0] = 5'd7;
    tick();
    #1;
    check("pre-upd q_hit", 32'(q_hit[0]), 32'h1);
    check("pre-upd q_rdy", 32'(q_rdy[0]), 32'h0);
    upd_en[1][1] = 1'b1; upd_data[1][1] = 32'hABCD;
    #1;
    check("upd q_rdy", 32'(q_rdy[0]), 32'h1);
    check("upd q_data", q_data[0], 32'hABCD);
    tick();
    idle_inputs();
    check("upd out_valid", 32'(out_valid), 32'h2);
    check("upd out_data1", out_data[1], 32'hABCD);
    check("upd out_dst1", 32'(out_dst[1]), 32'h7);
    tick();

    // Bypass priority: stage2 {l0 d=1}, stage1 {l0 d=4, l1 d=2}, stage0 non-hitters.
    in_valid = 2'b11; in_wen = 2'b01; in_rdy = 2'b11;
    in_dst[0] = 5'd3; in_data[0] = 32'd1; in_dst[1] = 5'd9; in_data[1] = 32'd9;
    tick();
    in_wen = 2'b11;
    in_dst[0] = 5'd3; in_data[0] = 32'd4; in_dst[1] = 5'd3; in_data[1] = 32'd2;
    tick();
    in_wen = 2'b10;
    in_dst[0] = 5'd9; in_data[0] = 32'd7; in_dst[1] = 5'd0; in_data[1] = 32'd8;
    tick();
    idle_inputs();
    q_reg[0] = 5'd3; q_reg[1] = 5'd0; q_reg[2] = 5'd9; q_reg[3] = 5'd12;
    #1;
    check("byp q_hit", 32'(q_hit), 32'h1);
    check("byp q_data", q_data[0], 32'd2);
    check("byp q_rdy", 32'(q_rdy[0]), 32'h1);
    check("byp miss q_data", q_data[3], 32'h0);
    check("byp zero q_data", q_data[1], 32'h0);

    // Stall with update on stage 0: captured in place, seen at commit later.
    upd_en[0][1] = 1'b1; upd_data[0][1] = 32'h55; stall = 1'b1;
    tick();
    idle_inputs();
    check("stall bubble", 32'(out_valid), 32'h0);
    tick(); tick();
    check("stall upd out_valid", 32'(out_valid), 32'h3);
    check("stall upd out_data1", out_data[1], 32'h55);
    check("wen masked out_wen", 32'(out_wen), 32'h2);

    // Reset mid-operation, with updates present, clears everything.
    in_valid = 2'b11; in_wen = 2'b11;
    tick();
    idle_inputs();
    resetn = 1'b0; upd_en = '1;
    tick();
    check("midreset busy", 32'(busy), 32'h0);
    check("midreset out_valid", 32'(out_valid), 32'h0);
    resetn = 1'b1; upd_en = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
